// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, done strobe and frame error flag

module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_busy
);

  // Clocks per bit must stay within 4..65535 so the 16-bit counter and the
  // half-bit sample point remain meaningful.
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int HALF         = BAUD_CNT_MAX / 2;
  localparam logic [15:0] BIT_END   = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] SAMPLE_PT = 16'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nx;
  logic        rxd_m, rxd_s, rxd_d;
  logic        fall;
  logic [15:0] baud_cnt, baud_cnt_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  shift, shift_nx;
  logic [7:0]  data_nx;
  logic        done_nx, err_nx;
  logic        at_sample, at_bit_end;

  // Two-flop synchroniser plus one delay flop for falling-edge detection;
  // resetting to 0 means a line held low through reset is never seen as a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m <= 1'b0;
      rxd_s <= 1'b0;
      rxd_d <= 1'b0;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall       = rxd_d & ~rxd_s;
  assign at_sample  = (baud_cnt == SAMPLE_PT);
  assign at_bit_end = (baud_cnt == BIT_END);
  assign uart_rx_busy = (state != IDLE);

  // State, counters, shift register and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      baud_cnt          <= 16'd0;
      bit_cnt           <= 3'd0;
      shift             <= 8'h00;
      uart_rx_data      <= 8'h00;
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
    end else begin
      state             <= state_nx;
      baud_cnt          <= baud_cnt_nx;
      bit_cnt           <= bit_cnt_nx;
      shift             <= shift_nx;
      uart_rx_data      <= data_nx;
      uart_rx_done      <= done_nx;
      uart_rx_frame_err <= err_nx;
    end
  end

  // Next-state logic; STOP returns to IDLE at mid-bit so a back-to-back start edge is caught.
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = at_bit_end ? 16'd0 : baud_cnt + 16'd1;
    bit_cnt_nx  = bit_cnt;
    shift_nx    = shift;
    data_nx     = uart_rx_data;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_nx = 16'd0;
        if (fall) begin
          state_nx = START;
        end
      end
      START: begin
        if (at_sample && rxd_s) begin
          state_nx    = IDLE;
          baud_cnt_nx = 16'd0;
        end else if (at_bit_end) begin
          state_nx   = DATA;
          bit_cnt_nx = 3'd0;
        end
      end
      DATA: begin
        if (at_sample) begin
          shift_nx = {rxd_s, shift[7:1]};
        end
        if (at_bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (at_sample) begin
          state_nx    = IDLE;
          baud_cnt_nx = 16'd0;
          if (rxd_s) begin
            data_nx = shift;
            done_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx    = IDLE;
        baud_cnt_nx = 16'd0;
      end
    endcase
  end

endmodule
